// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB request arbiter: FSM states,
// requester index sizing and response error encodings.
package apb_arb_pkg;

    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned IDX_W   = $clog2(MAX_REQ);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_e;

    localparam logic RSP_OK      = 1'b0;
    localparam logic RSP_SLVERR  = 1'b1;
    localparam logic RSP_TIMEOUT = 1'b1;

    // One-hot requester vector for a granted index
    function automatic logic [MAX_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        idx_onehot = MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Round-robin picker: first eligible request at or after the pointer,
// searching upward with wrap-around.
module apb_rr_pick
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_grant_valid,
    output logic [IDX_W-1:0]   o_grant_idx
);

    localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);

    logic [MAX_REQ-1:0] w_req_ext;
    logic [IDX_W:0]     w_cand;

    assign w_req_ext = MAX_REQ'(i_req);

    // Walk from the farthest rotated slot back to the pointer so the nearest hit wins
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        w_cand        = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_cand >= NREQ) begin
                w_cand = w_cand - NREQ;
            end
            if (w_req_ext[w_cand[IDX_W-1:0]]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB3 master port among NUM_REQ requesters.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS phases stuck longer than TIMEOUT_CYCLES.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ-1:0]        REQ_WRITE,
    input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_WDATA,
    output logic [NUM_REQ-1:0]        DONE,
    output logic [DATA_W-1:0]         RSP_RDATA,
    output logic                      RSP_ERR,
    output logic                      BUSY,
    output logic [ADDR_W-1:0]         PADDR,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("apb_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_e         r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]   r_owner, w_owner_nxt;
    logic [ADDR_W-1:0]  r_paddr, w_paddr_nxt;
    logic               r_psel, w_psel_nxt;
    logic               r_penable, w_penable_nxt;
    logic               r_pwrite, w_pwrite_nxt;
    logic [DATA_W-1:0]  r_pwdata, w_pwdata_nxt;
    logic [NUM_REQ-1:0] r_done, w_done_nxt;
    logic [DATA_W-1:0]  r_rdata, w_rdata_nxt;
    logic               r_err, w_err_nxt;
    logic               r_busy, w_busy_nxt;

    logic [NUM_REQ-1:0] w_elig;
    logic               w_grant_valid;
    logic [IDX_W-1:0]   w_grant_idx;
    logic [IDX_W:0]     w_ptr_inc;
    logic               w_tmo_hit;

    // A requester being told DONE this cycle must not be re-granted on the same stale request
    assign w_elig    = REQ & ~r_done;
    assign w_ptr_inc = {1'b0, w_grant_idx} + (IDX_W+1)'(1);

    apb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req         (w_elig),
        .i_ptr         (r_ptr),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;

    assign w_tmo_hit = (r_state == ST_ACCESS) && !PREADY &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_tmo_cnt_nxt = r_tmo_cnt;
        if (w_state_nxt == ST_SETUP) begin
            w_tmo_cnt_nxt = '0;
        end else if (r_state == ST_ACCESS) begin
            w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= w_tmo_cnt_nxt;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_owner_nxt   = r_owner;
        w_paddr_nxt   = r_paddr;
        w_pwrite_nxt  = r_pwrite;
        w_pwdata_nxt  = r_pwdata;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_done_nxt    = '0;
        w_rdata_nxt   = '0;
        w_err_nxt     = RSP_OK;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt  = ST_SETUP;
                    w_owner_nxt  = w_grant_idx;
                    w_ptr_nxt    = (w_ptr_inc == (IDX_W+1)'(NUM_REQ)) ? '0 : w_ptr_inc[IDX_W-1:0];
                    w_paddr_nxt  = REQ_ADDR[int'(w_grant_idx) * ADDR_W +: ADDR_W];
                    w_pwdata_nxt = REQ_WDATA[int'(w_grant_idx) * DATA_W +: DATA_W];
                    w_pwrite_nxt = REQ_WRITE[w_grant_idx];
                    w_psel_nxt   = 1'b1;
                end
            end
            ST_SETUP: begin
                w_state_nxt   = ST_ACCESS;
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
            end
            ST_ACCESS: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
                if (PREADY) begin
                    w_state_nxt   = ST_IDLE;
                    w_psel_nxt    = 1'b0;
                    w_penable_nxt = 1'b0;
                    w_done_nxt    = NUM_REQ'(idx_onehot(r_owner));
                    w_rdata_nxt   = r_pwrite ? '0 : PRDATA;
                    w_err_nxt     = PSLVERR ? RSP_SLVERR : RSP_OK;
                end else if (w_tmo_hit) begin
                    w_state_nxt   = ST_IDLE;
                    w_psel_nxt    = 1'b0;
                    w_penable_nxt = 1'b0;
                    w_done_nxt    = NUM_REQ'(idx_onehot(r_owner));
                    w_err_nxt     = RSP_TIMEOUT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_paddr   <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_done    <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_owner   <= w_owner_nxt;
            r_paddr   <= w_paddr_nxt;
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
            r_pwrite  <= w_pwrite_nxt;
            r_pwdata  <= w_pwdata_nxt;
            r_done    <= w_done_nxt;
            r_rdata   <= w_rdata_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign DONE      = r_done;
    assign RSP_RDATA = r_rdata;
    assign RSP_ERR   = r_err;
    assign BUSY      = r_busy;
    assign PADDR     = r_paddr;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;

endmodule
